// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: command, memory-port and stream signals of mem_stream_reader.
// MEM_STREAM_READER_LAST_EN adds out_last to the stream.
interface mem_stream_reader_if #(
    parameter int DEPTH    = 8,
    parameter int BIT_SIZE = 16
);
    logic                start;
    logic [DEPTH-1:0]    base_addr;
    logic [DEPTH:0]      length;
    logic                busy;
    logic                done;
    logic [DEPTH-1:0]    read_addr;
    logic [BIT_SIZE-1:0] mem_data;
    logic                out_valid;
    logic                out_ready;
    logic [BIT_SIZE-1:0] out_data;
`ifdef MEM_STREAM_READER_LAST_EN
    logic                out_last;
`endif

    modport master (
        input  start, base_addr, length, mem_data, out_ready,
        output busy, done, read_addr, out_valid, out_data
`ifdef MEM_STREAM_READER_LAST_EN
        , output out_last
`endif
    );

    modport slave (
        output start, base_addr, length, mem_data, out_ready,
        input  busy, done, read_addr, out_valid, out_data
`ifdef MEM_STREAM_READER_LAST_EN
        , input out_last
`endif
    );
endinterface

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: burst read sequencer for a synchronous-read memory, streaming words through a 2-entry skid FIFO.
// MEM_STREAM_READER_LAST_EN adds out_last, tagging the final word of each burst.
module mem_stream_reader #(
    parameter int DEPTH    = 8,
    parameter int BIT_SIZE = 16
) (
    input logic                 clk,
    input logic                 reset,
    mem_stream_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    addr_q, addr_d;
    logic [DEPTH:0]      remaining_q, remaining_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          count_q, count_d;
    logic [BIT_SIZE-1:0] data0_q, data0_d, data1_q, data1_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                pop, issue;
    logic [1:0]          wr_idx;
    logic [2:0]          occ;
`ifdef MEM_STREAM_READER_LAST_EN
    logic                tag_q, tag_d, last0_q, last0_d, last1_q, last1_d;
`endif

    always_comb begin
        pop         = (count_q != 2'd0) && bus.out_ready;
        wr_idx      = count_q - {1'b0, pop};
        occ         = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue       = (state_q == READ) && (remaining_q != '0) && (occ < 3'd2);
        inflight_d  = issue;
        count_d     = count_q + {1'b0, inflight_q} - {1'b0, pop};
        // The word returning from memory lands in the first free slot after this cycle's pop shift.
        data0_d     = (inflight_q && wr_idx == 2'd0) ? bus.mem_data : pop ? data1_q : data0_q;
        data1_d     = (inflight_q && wr_idx != 2'd0) ? bus.mem_data : data1_q;
`ifdef MEM_STREAM_READER_LAST_EN
        tag_d       = issue ? (remaining_q == (DEPTH+1)'(1)) : tag_q;
        last0_d     = (inflight_q && wr_idx == 2'd0) ? tag_q : pop ? last1_q : last0_q;
        last1_d     = (inflight_q && wr_idx != 2'd0) ? tag_q : last1_q;
`endif
        state_d     = state_q;
        addr_d      = issue ? addr_q + DEPTH'(1) : addr_q;
        remaining_d = issue ? remaining_q - (DEPTH+1)'(1) : remaining_q;
        case (state_q)
            IDLE: if (bus.start) begin
                addr_d      = bus.base_addr;
                remaining_d = bus.length;
                state_d     = (bus.length != '0) ? READ : DONE;
            end
            READ:  state_d = (issue && remaining_q == (DEPTH+1)'(1)) ? DRAIN : READ;
            DRAIN: state_d = (!inflight_q && wr_idx == 2'd0) ? DONE : DRAIN;
            DONE:  state_d = IDLE;
        endcase
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef MEM_STREAM_READER_LAST_EN
            tag_q       <= 1'b0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef MEM_STREAM_READER_LAST_EN
            tag_q       <= tag_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
`endif
        end
    end

    assign bus.read_addr = addr_q;
    assign bus.out_valid = count_q != 2'd0;
    assign bus.out_data  = data0_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef MEM_STREAM_READER_LAST_EN
    assign bus.out_last  = last0_q && (count_q != 2'd0);
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: directed bench for mem_stream_reader with a synchronous-read memory model.
// Honours MEM_STREAM_READER_LAST_EN when defined.
module tb_mem_stream_reader;
    localparam int DEPTH = 8, BIT_SIZE = 16;

    logic clk = 1'b0;
    logic reset;
    int total = 0, bad = 0;
    logic [BIT_SIZE-1:0] mem [0:255];

    mem_stream_reader_if #(.DEPTH(DEPTH), .BIT_SIZE(BIT_SIZE)) bus ();
    mem_stream_reader #(.DEPTH(DEPTH), .BIT_SIZE(BIT_SIZE)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) bus.mem_data <= mem[bus.read_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1, 2: random ready; poke re-asserts start while busy
    task automatic burst(input string tag, input logic [7:0] base, input int len, input int mode, input bit poke);
        int got = 0, issued = 0, cyc = 0;
        bit seen_done = 0, stalled = 0;
        logic [15:0] held = '0;
        logic [7:0] prev_addr = base;
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.length = 9'(len);
        @(negedge clk);
        bus.start = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (poke) begin
                bus.start = (cyc == 0);
                bus.base_addr = 8'h80;
                bus.length = 9'd5;
            end
            if (bus.read_addr !== prev_addr) begin
                issued++;
                prev_addr = bus.read_addr;
                check({tag, " read_addr"}, 32'(bus.read_addr), 32'(8'(base + 8'(issued))));
            end
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
            if (stalled) check({tag, " stall hold"}, 32'(bus.out_data), 32'(held));
            check({tag, " occupancy"}, 32'(issued - got <= 2), 32'd1);
            if (bus.out_valid && bus.out_ready) begin
                check({tag, " data"}, 32'(bus.out_data), 32'(mem[8'(base + 8'(got))]));
`ifdef MEM_STREAM_READER_LAST_EN
                check({tag, " last"}, 32'(bus.out_last), 32'(got == len - 1));
`endif
                got++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            if (bus.done) begin
                seen_done = 1'b1;
                check({tag, " words"}, 32'(got), 32'(len));
                check({tag, " valid at done"}, 32'(bus.out_valid), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " done seen"}, 32'(seen_done), 32'd1);
        check({tag, " idle after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst valid", 32'(bus.out_valid), 32'd0);
        check("rst read_addr", 32'(bus.read_addr), 32'd0);
`ifdef MEM_STREAM_READER_LAST_EN
        check("rst last", 32'(bus.out_last), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // single burst with exact cycle timing
        bus.start = 1'b1;
        bus.base_addr = 8'h10;
        bus.length = 9'd4;
        @(negedge clk);
        bus.start = 1'b0;
        check("b1 busy", 32'(bus.busy), 32'd1);
        check("b1 addr0", 32'(bus.read_addr), 32'h10);
        check("b1 valid c1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("b1 valid c2", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("b1 valid c3", 32'(bus.out_valid), 32'd1);
        check("b1 w0", 32'(bus.out_data), 32'h30);
        @(negedge clk);
        check("b1 w1", 32'(bus.out_data), 32'h33);
        @(negedge clk);
        check("b1 w2", 32'(bus.out_data), 32'h36);
        @(negedge clk);
        check("b1 valid w3", 32'(bus.out_valid), 32'd1);
        check("b1 w3", 32'(bus.out_data), 32'h39);
        check("b1 no early done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("b1 valid end", 32'(bus.out_valid), 32'd0);
        check("b1 done", 32'(bus.done), 32'd1);
        @(negedge clk);
        check("b1 done pulse", 32'(bus.done), 32'd0);
        check("b1 busy end", 32'(bus.busy), 32'd0);

        burst("bp", 8'h50, 6, 1, 1'b0);
        burst("wrap", 8'hFE, 4, 0, 1'b0);

        // zero length
        bus.start = 1'b1;
        bus.length = 9'd0;
        @(negedge clk);
        bus.start = 1'b0;
        check("z done", 32'(bus.done), 32'd1);
        check("z busy", 32'(bus.busy), 32'd1);
        check("z valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("z done low", 32'(bus.done), 32'd0);
        check("z busy low", 32'(bus.busy), 32'd0);
        check("z valid2", 32'(bus.out_valid), 32'd0);

        burst("ign", 8'h40, 3, 0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("ign quiet valid", 32'(bus.out_valid), 32'd0);
            check("ign quiet busy", 32'(bus.busy), 32'd0);
        end

        // mid-burst reset after 3 pops
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        bus.base_addr = 8'h00;
        bus.length = 9'd8;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("mr pop", 32'(bus.out_data), 32'(k * 3));
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        check("mr valid", 32'(bus.out_valid), 32'd0);
        check("mr busy", 32'(bus.busy), 32'd0);
        check("mr addr", 32'(bus.read_addr), 32'd0);
        repeat (5) begin
            check("mr no done", 32'(bus.done), 32'd0);
            check("mr no valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        burst("after rst", 8'h20, 2, 0, 1'b0);

        burst("rand3", 8'hA0, 3, 2, 1'b0);
        burst("len1", 8'h05, 1, 2, 1'b0);
        burst("full", 8'h37, 256, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
